// File: rtl/seg7_scan_driver_if.sv
// Bus between the BCD scan counter, the display pins and seg7_scan_driver.
// The master drives the digit stream and controls; the slave drives the display.
interface seg7_scan_driver_if;
  logic [3:0] bcdcode;
  logic [1:0] scan;
  logic       lz_en;
  logic [2:0] bright;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] com;
  logic       err;

  modport master (
    output bcdcode, scan, lz_en, bright,
    input  seg, dp, com, err
  );

  modport slave (
    input  bcdcode, scan, lz_en, bright,
    output seg, dp, com, err
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver: buffers the scanned BCD stream and
// drives the display with dead time, leading-zero blanking and PWM dimming.
module seg7_scan_driver #(
  parameter int DEAD_CYC = 4,
  parameter bit SEG_INV  = 1'b0,
  parameter bit COM_INV  = 1'b0
) (
  input logic               clk,
  input logic               p3_rst,
  seg7_scan_driver_if.slave bus
);

  localparam int               CNT_W     = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [6:0]       SEG_OFF   = {7{SEG_INV}};
  localparam logic [3:0]       COM_OFF   = {4{COM_INV}};

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_DEAD,
    ST_DRIVE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [3:0]       bcd_r_q, bcd_r_d;
  logic [1:0]       scan_r_q, scan_r_d;
  logic [1:0]       scan_rr_q, scan_rr_d;
  logic [3:0][3:0]  dig_buf_q, dig_buf_d;
  logic             err_q, err_d;
  logic [2:0]       pwm_cnt_q, pwm_cnt_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       com_q, com_d;
  logic             evt;
  logic [3:0]       blk;
  logic             blank;
  logic             pwm_on;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Outputs use scan_rr so that on the cycle a new scan index arrives the old
  // digit is still the one shown; this keeps com strictly one-hot.
  always_comb begin
    evt        = (scan_r_q != scan_rr_q);
    bcd_r_d    = bus.bcdcode;
    scan_r_d   = bus.scan;
    scan_rr_d  = scan_r_q;
    dig_buf_d  = dig_buf_q;
    err_d      = err_q;
    pwm_cnt_d  = pwm_cnt_q + 3'd1;
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    seg_d      = SEG_OFF;
    com_d      = COM_OFF;

    if (evt) begin
      dig_buf_d[scan_r_q] = bcd_r_q;
      if (bcd_r_q > 4'd9) begin
        err_d = 1'b1;
      end
    end

    blk[0] = (dig_buf_q[0] == 4'd0);
    blk[1] = blk[0] && (dig_buf_q[1] == 4'd0);
    blk[2] = blk[1] && (dig_buf_q[2] == 4'd0);
    blk[3] = 1'b0;
    blank  = bus.lz_en && blk[scan_rr_q];
    pwm_on = (pwm_cnt_q <= bus.bright);

    case (state_q)
      ST_BLANK: begin
        if (evt) begin
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (evt) begin
          dead_cnt_d = DEAD_LOAD;
        end else if (dead_cnt_q == '0) begin
          state_d = ST_DRIVE;
        end else begin
          dead_cnt_d = dead_cnt_q - CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (evt) begin
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
        end
      end
      default: begin
        state_d = ST_BLANK;
      end
    endcase

    if (state_q == ST_DRIVE) begin
      seg_d = decode(dig_buf_q[scan_rr_q]) ^ SEG_OFF;
      if (pwm_on && !blank) begin
        com_d = (4'b0001 << scan_rr_q) ^ COM_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge p3_rst) begin
    if (p3_rst) begin
      state_q    <= ST_BLANK;
      dead_cnt_q <= '0;
      bcd_r_q    <= '0;
      scan_r_q   <= '0;
      scan_rr_q  <= '0;
      dig_buf_q  <= '0;
      err_q      <= 1'b0;
      pwm_cnt_q  <= '0;
      seg_q      <= SEG_OFF;
      com_q      <= COM_OFF;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
      bcd_r_q    <= bcd_r_d;
      scan_r_q   <= scan_r_d;
      scan_rr_q  <= scan_rr_d;
      dig_buf_q  <= dig_buf_d;
      err_q      <= err_d;
      pwm_cnt_q  <= pwm_cnt_d;
      seg_q      <= seg_d;
      com_q      <= com_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.com = com_q;
  assign bus.err = err_q;
  assign bus.dp  = SEG_INV;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: each scan change that should light a
// digit queues the expected com/seg/latency, popped when that digit turns on.
module tb_seg7_scan_driver;

  localparam int DEAD_CYC = 4;
  localparam int LAT      = DEAD_CYC + 2;

  typedef struct {
    logic [3:0] com;
    logic [6:0] seg;
    int         edgeNum;
  } expEntry_t;

  logic clk = 1'b0;
  logic p3_rst;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .DEAD_CYC(DEAD_CYC),
    .SEG_INV (1'b0),
    .COM_INV (1'b0)
  ) dut (
    .clk   (clk),
    .p3_rst(p3_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  expEntry_t  expQ[$];
  int         cycle = 0;
  int         nChecks = 0;
  int         nFails = 0;
  int         multiOn = 0;
  int         comActive = 0;
  bit         monEn = 1'b1;
  bit         countEn = 1'b0;
  logic [3:0] prevCom = 4'b0;
  logic [3:0] mBuf [4];
  logic [1:0] lastScan;
  logic       mErr;
  logic [6:0] segTable [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [6:0] segModel(input logic [3:0] v);
    if (v > 4'd9) return 7'h40;
    return segTable[v];
  endfunction

  // Drive one (scan, bcdcode) pair held for `hold` clocks; a scan change that
  // is long enough to reach DRIVE and is not blanked queues its expected digit.
  task automatic applyStimulus(input logic [1:0] sc, input logic [3:0] digit, input int hold);
    bit        b0, b1, b2, blank;
    expEntry_t e;
    @(posedge clk);
    #1;
    bus.scan    = sc;
    bus.bcdcode = digit;
    if (sc != lastScan) begin
      mBuf[sc] = digit;
      if (digit > 4'd9) mErr = 1'b1;
      lastScan = sc;
      b0 = (mBuf[0] == 4'd0);
      b1 = b0 && (mBuf[1] == 4'd0);
      b2 = b1 && (mBuf[2] == 4'd0);
      blank = bus.lz_en && ((sc == 2'd0) ? b0 : (sc == 2'd1) ? b1 : (sc == 2'd2) ? b2 : 1'b0);
      if (!blank && hold >= LAT - 1) begin
        e.com     = 4'b0001 << sc;
        e.seg     = segModel(digit);
        e.edgeNum = cycle + 1;
        expQ.push_back(e);
      end
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    expEntry_t e;
    if ($countones(bus.com) > 1) multiOn++;
    if (countEn && bus.com != 4'b0) comActive++;
    if (monEn && prevCom == 4'b0 && bus.com != 4'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_com", {28'b0, bus.com}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("com", {28'b0, bus.com}, {28'b0, e.com});
        checkOutput("seg", {25'b0, bus.seg}, {25'b0, e.seg});
        checkOutput("latency", cycle - e.edgeNum, LAT);
      end
    end
    prevCom = bus.com;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pwmOn;
    p3_rst      = 1'b1;
    bus.scan    = 2'd0;
    bus.bcdcode = 4'd0;
    bus.lz_en   = 1'b0;
    bus.bright  = 3'd7;
    for (int i = 0; i < 4; i++) mBuf[i] = 4'd0;
    lastScan = 2'd0;
    mErr     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_com", {28'b0, bus.com}, 32'd0);
    checkOutput("rst_seg", {25'b0, bus.seg}, 32'd0);
    checkOutput("rst_err", {31'b0, bus.err}, 32'd0);
    checkOutput("rst_dp", {31'b0, bus.dp}, 32'd0);
    @(posedge clk);
    #1 p3_rst = 1'b0;

    $display("[TB] digits 1,2,3,4 at full brightness");
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++) applyStimulus(2'(s), 4'(s + 1), 12);

    $display("[TB] leading-zero blanking");
    bus.lz_en = 1'b1;
    applyStimulus(2'd0, 4'd0, 12);
    applyStimulus(2'd1, 4'd0, 12);
    applyStimulus(2'd2, 4'd7, 12);
    applyStimulus(2'd3, 4'd0, 12);
    for (int s = 0; s < 4; s++) applyStimulus(2'(s), 4'd0, 12);
    bus.lz_en = 1'b0;
    for (int s = 0; s < 4; s++) applyStimulus(2'(s), 4'd0, 12);

    $display("[TB] PWM brightness 2");
    applyStimulus(2'd1, 4'd5, 10);
    monEn = 1'b0;
    bus.bright = 3'd2;
    repeat (2) @(posedge clk);
    pwmOn = 0;
    repeat (64) begin
      @(negedge clk);
      if (bus.com == 4'b0010) pwmOn++;
    end
    checkOutput("pwm_duty", pwmOn, 32'd24);
    bus.bright = 3'd7;
    repeat (3) @(posedge clk);
    monEn = 1'b1;

    $display("[TB] scan faster than dead time");
    comActive = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) countEn = 1'b1;
      applyStimulus(2'(i), 4'((i % 9) + 1), 2);
    end
    countEn = 1'b0;
    checkOutput("fast_no_com", comActive, 32'd0);
    checkOutput("one_hot", multiOn, 32'd0);

    $display("[TB] invalid code flagging");
    checkOutput("err_before", {31'b0, bus.err}, 32'd0);
    applyStimulus(2'd0, 4'd5, 10);
    applyStimulus(2'd1, 4'd6, 10);
    applyStimulus(2'd2, 4'd12, 10);
    checkOutput("err_set", {31'b0, bus.err}, {31'b0, mErr});
    applyStimulus(2'd3, 4'd8, 10);
    for (int s = 0; s < 4; s++) applyStimulus(2'(s), 4'(s + 5), 10);
    checkOutput("err_sticky", {31'b0, bus.err}, {31'b0, mErr});

    $display("[TB] reset while driving");
    @(negedge clk);
    p3_rst      = 1'b1;
    bus.scan    = 2'd0;
    bus.bcdcode = 4'd0;
    #1;
    checkOutput("midrst_com", {28'b0, bus.com}, 32'd0);
    checkOutput("midrst_seg", {25'b0, bus.seg}, 32'd0);
    checkOutput("midrst_err", {31'b0, bus.err}, 32'd0);
    for (int i = 0; i < 4; i++) mBuf[i] = 4'd0;
    lastScan = 2'd0;
    mErr     = 1'b0;
    repeat (2) @(posedge clk);
    #1 p3_rst = 1'b0;
    bus.lz_en = 1'b1;
    applyStimulus(2'd2, 4'd0, 10);
    applyStimulus(2'd3, 4'd0, 10);
    checkOutput("post_rst_err", {31'b0, bus.err}, 32'd0);

    repeat (4) @(posedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    checkOutput("one_hot_final", multiOn, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
